// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: hazard/redirect controls, instruction-memory fields,
// and the registered IF/ID outputs handed to decode.
interface fetch_stage_if;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;

  logic [31:0] imem_addr;
  logic [5:0]  if_ctrl;
  logic [4:0]  if_rs;
  logic [4:0]  if_rt;
  logic [4:0]  if_rd;
  logic [4:0]  if_shamt;
  logic [5:0]  if_function;
  logic [25:0] if_jump;
  logic [15:0] if_sign_ext;

  logic [5:0]  id_ctrl;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [4:0]  id_shamt;
  logic [5:0]  id_function;
  logic [25:0] id_jump;
  logic [15:0] id_sign_ext;
  logic [31:0] id_pc_plus4;
  logic        id_valid;

  logic [31:0] pc;
  logic        misalign;
  logic [31:0] fetch_count;

  modport master (
    output stall, flush, branch_taken, branch_target,
    output jump, jump_index,
    output if_ctrl, if_rs, if_rt, if_rd, if_shamt,
    output if_function, if_jump, if_sign_ext,
    input  imem_addr,
    input  id_ctrl, id_rs, id_rt, id_rd, id_shamt,
    input  id_function, id_jump, id_sign_ext,
    input  id_pc_plus4, id_valid,
    input  pc, misalign, fetch_count
  );

  modport slave (
    input  stall, flush, branch_taken, branch_target,
    input  jump, jump_index,
    input  if_ctrl, if_rs, if_rt, if_rd, if_shamt,
    input  if_function, if_jump, if_sign_ext,
    output imem_addr,
    output id_ctrl, id_rs, id_rt, id_rd, id_shamt,
    output id_function, id_jump, id_sign_ext,
    output id_pc_plus4, id_valid,
    output pc, misalign, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// PC generation and IF/ID pipeline register for the MIPS core.
// Redirect priority: jump, then branch, then flush/stall, then pc+4.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.slave  bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic [5:0]  ctrl;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [25:0] jidx;
    logic [15:0] sext;
    logic [31:0] pc_plus4;
    logic        valid;
  } id_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;
  logic        mis_q, mis_d;
  id_t         id_q, id_d;

  logic [31:0] pc_plus4;
  logic [31:0] jump_tgt;
  logic [31:0] br_tgt;
  id_t         fetched;

  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    jump_tgt = {pc_plus4[31:28], bus.jump_index, 2'b00};
    br_tgt   = {bus.branch_target[31:2], 2'b00};

    fetched          = '0;
    fetched.ctrl     = bus.if_ctrl;
    fetched.rs       = bus.if_rs;
    fetched.rt       = bus.if_rt;
    fetched.rd       = bus.if_rd;
    fetched.shamt    = bus.if_shamt;
    fetched.funct    = bus.if_function;
    fetched.jidx     = bus.if_jump;
    fetched.sext     = bus.if_sign_ext;
    fetched.pc_plus4 = pc_plus4;
    fetched.valid    = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    id_d    = id_q;

    unique case (state_q)
      BOOT: begin
        // memory settle cycle: pc held, IF/ID stays empty
        state_d = RUN;
      end
      RUN, HOLD: begin
        priority case (1'b1)
          bus.jump: begin
            pc_d    = jump_tgt;
            id_d    = '0;
            state_d = RUN;
          end
          bus.branch_taken: begin
            pc_d    = br_tgt;
            id_d    = '0;
            mis_d   = mis_q | (|bus.branch_target[1:0]);
            state_d = RUN;
          end
          bus.flush: begin
            id_d = '0;
            if (!bus.stall) begin
              pc_d    = pc_plus4;
              state_d = RUN;
            end
          end
          bus.stall: begin
            state_d = HOLD;
          end
          default: begin
            pc_d    = pc_plus4;
            id_d    = fetched;
            cnt_d   = cnt_q + 32'd1;
            state_d = RUN;
          end
        endcase
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      id_q    <= id_d;
    end
  end

  assign bus.imem_addr   = {2'b00, pc_q[31:2]};
  assign bus.pc          = pc_q;
  assign bus.misalign    = mis_q;
  assign bus.fetch_count = cnt_q;

  assign bus.id_ctrl     = id_q.ctrl;
  assign bus.id_rs       = id_q.rs;
  assign bus.id_rt       = id_q.rt;
  assign bus.id_rd       = id_q.rd;
  assign bus.id_shamt    = id_q.shamt;
  assign bus.id_function = id_q.funct;
  assign bus.id_jump     = id_q.jidx;
  assign bus.id_sign_ext = id_q.sext;
  assign bus.id_pc_plus4 = id_q.pc_plus4;
  assign bus.id_valid    = id_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, then random traffic
// checked against a rule-level reference model.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // reference model state
  bit          m_boot;
  logic [31:0] m_pc;
  logic [73:0] m_f;
  logic [31:0] m_pp4;
  logic        m_v;
  logic [31:0] m_cnt;
  logic        m_mis;

  typedef struct {
    bit          rst_n;
    bit          stall;
    bit          flush;
    bit          br;
    logic [31:0] bta;
    bit          jump;
    logic [25:0] ji;
    logic [31:0] e_pc;
    logic        e_v;
    logic [31:0] e_pp4;
    logic [31:0] e_cnt;
    logic        e_mis;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [73:0] act,
                       input logic [73:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [73:0] id_fields();
    return {bus.id_ctrl, bus.id_rs, bus.id_rt, bus.id_rd, bus.id_shamt,
            bus.id_function, bus.id_jump, bus.id_sign_ext};
  endfunction

  task automatic model_step(input bit rst, input bit st, input bit fl,
                            input bit bt, input logic [31:0] bta,
                            input bit j, input logic [25:0] ji,
                            input logic [73:0] f);
    logic [31:0] seq;
    seq = m_pc + 32'd4;
    if (!rst) begin
      m_boot = 1; m_pc = RST_PC; m_f = '0; m_pp4 = '0;
      m_v = 0; m_cnt = '0; m_mis = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (j) begin
      m_pc = (seq & 32'hF000_0000) | ({6'd0, ji} * 32'd4);
      m_f = '0; m_pp4 = '0; m_v = 0;
    end else if (bt) begin
      m_pc = bta - (bta % 4);
      if (bta % 4 != 0) m_mis = 1;
      m_f = '0; m_pp4 = '0; m_v = 0;
    end else if (fl) begin
      m_f = '0; m_pp4 = '0; m_v = 0;
      if (!st) m_pc = seq;
    end else if (!st) begin
      m_f = f; m_pp4 = seq; m_v = 1;
      m_cnt = m_cnt + 1;
      m_pc = seq;
    end
  endtask

  task automatic check_model();
    check("pc", {42'd0, bus.pc}, {42'd0, m_pc});
    check("imem_addr", {42'd0, bus.imem_addr}, {42'd0, m_pc / 4});
    check("id_valid", {73'd0, bus.id_valid}, {73'd0, m_v});
    check("id_pc_plus4", {42'd0, bus.id_pc_plus4}, {42'd0, m_pp4});
    check("id_fields", id_fields(), m_f);
    check("fetch_count", {42'd0, bus.fetch_count}, {42'd0, m_cnt});
    check("misalign", {73'd0, bus.misalign}, {73'd0, m_mis});
  endtask

  task automatic cycle(input bit rst, input bit st, input bit fl,
                       input bit bt, input logic [31:0] bta,
                       input bit j, input logic [25:0] ji);
    logic [95:0] r;
    logic [73:0] f;
    r = {$urandom(), $urandom(), $urandom()};
    f = r[73:0];
    rst_n = rst;
    bus.stall = st;
    bus.flush = fl;
    bus.branch_taken = bt;
    bus.branch_target = bta;
    bus.jump = j;
    bus.jump_index = ji;
    {bus.if_ctrl, bus.if_rs, bus.if_rt, bus.if_rd, bus.if_shamt,
     bus.if_function, bus.if_jump, bus.if_sign_ext} = f;
    @(posedge clk);
    #1;
    model_step(rst, st, fl, bt, bta, j, ji, f);
    check_model();
  endtask

  function automatic vec_t mk(input bit r, input bit s, input bit fl,
                              input bit b, input logic [31:0] ba,
                              input bit j, input logic [25:0] ji,
                              input logic [31:0] pc, input logic v,
                              input logic [31:0] pp4, input logic [31:0] c,
                              input logic mis);
    vec_t x;
    x.rst_n = r; x.stall = s; x.flush = fl; x.br = b; x.bta = ba;
    x.jump = j; x.ji = ji; x.e_pc = pc; x.e_v = v; x.e_pp4 = pp4;
    x.e_cnt = c; x.e_mis = mis;
    return x;
  endfunction

  initial begin
    rst_n = 1'b0;
    bus.stall = 0; bus.flush = 0; bus.branch_taken = 0;
    bus.branch_target = '0; bus.jump = 0; bus.jump_index = '0;
    m_boot = 1; m_pc = RST_PC; m_f = '0; m_pp4 = '0;
    m_v = 0; m_cnt = '0; m_mis = 0;

    //         rst s f b bta            j ji          pc             v pp4            cnt mis
    vecs.push_back(mk(0,0,0,0,32'h0,        0,26'h0,  32'h100,       0,32'h0,         0,0));
    vecs.push_back(mk(1,0,0,0,32'h0,        0,26'h0,  32'h100,       0,32'h0,         0,0));
    vecs.push_back(mk(1,0,0,0,32'h0,        0,26'h0,  32'h104,       1,32'h104,       1,0));
    vecs.push_back(mk(1,0,0,0,32'h0,        0,26'h0,  32'h108,       1,32'h108,       2,0));
    vecs.push_back(mk(1,1,0,0,32'h0,        0,26'h0,  32'h108,       1,32'h108,       2,0));
    vecs.push_back(mk(1,1,0,0,32'h0,        0,26'h0,  32'h108,       1,32'h108,       2,0));
    vecs.push_back(mk(1,0,0,0,32'h0,        0,26'h0,  32'h10C,       1,32'h10C,       3,0));
    vecs.push_back(mk(1,1,0,1,32'h200,      0,26'h0,  32'h200,       0,32'h0,         3,0));
    vecs.push_back(mk(1,0,0,0,32'h0,        0,26'h0,  32'h204,       1,32'h204,       4,0));
    vecs.push_back(mk(1,0,0,1,32'h202,      0,26'h0,  32'h200,       0,32'h0,         4,1));
    vecs.push_back(mk(1,0,0,0,32'h0,        0,26'h0,  32'h204,       1,32'h204,       5,1));
    vecs.push_back(mk(1,0,1,0,32'h0,        0,26'h0,  32'h208,       0,32'h0,         5,1));
    vecs.push_back(mk(1,1,1,0,32'h0,        0,26'h0,  32'h208,       0,32'h0,         5,1));
    vecs.push_back(mk(1,0,0,0,32'h0,        1,26'h40, 32'h100,       0,32'h0,         5,1));
    vecs.push_back(mk(1,0,0,1,32'h1000_0000,0,26'h0,  32'h1000_0000, 0,32'h0,         5,1));
    vecs.push_back(mk(1,0,0,1,32'h300,      1,26'h40, 32'h1000_0100, 0,32'h0,         5,1));
    vecs.push_back(mk(1,0,0,0,32'h0,        0,26'h0,  32'h1000_0104, 1,32'h1000_0104, 6,1));
    vecs.push_back(mk(0,1,0,0,32'h0,        1,26'h7,  32'h100,       0,32'h0,         0,0));
    vecs.push_back(mk(1,0,0,0,32'h0,        1,26'h10, 32'h100,       0,32'h0,         0,0));
    vecs.push_back(mk(1,0,0,0,32'h0,        0,26'h0,  32'h104,       1,32'h104,       1,0));
    vecs.push_back(mk(1,0,0,1,32'hFFFF_FFFC,0,26'h0,  32'hFFFF_FFFC, 0,32'h0,         1,0));
    vecs.push_back(mk(1,0,0,0,32'h0,        0,26'h0,  32'h0,         1,32'h0,         2,0));

    foreach (vecs[i]) begin
      cycle(vecs[i].rst_n, vecs[i].stall, vecs[i].flush, vecs[i].br,
            vecs[i].bta, vecs[i].jump, vecs[i].ji);
      check($sformatf("vec%0d_pc", i), {42'd0, bus.pc}, {42'd0, vecs[i].e_pc});
      check($sformatf("vec%0d_valid", i), {73'd0, bus.id_valid},
            {73'd0, vecs[i].e_v});
      check($sformatf("vec%0d_pp4", i), {42'd0, bus.id_pc_plus4},
            {42'd0, vecs[i].e_pp4});
      check($sformatf("vec%0d_cnt", i), {42'd0, bus.fetch_count},
            {42'd0, vecs[i].e_cnt});
      check($sformatf("vec%0d_mis", i), {73'd0, bus.misalign},
            {73'd0, vecs[i].e_mis});
    end

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] bta;
      bta = $urandom();
      if ($urandom_range(0, 3) != 0) bta[1:0] = 2'b00;
      cycle($urandom_range(0, 99) != 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 9) == 0,
            bta,
            $urandom_range(0, 11) == 0,
            26'($urandom()));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
